matrix_vector_sequencer: RTL and testbench

//  Parametrised control FSM for the matrix processor. Loads a DIMxDIM matrix, then streams

---
 rtl/mp_pkg.sv | 23 ++
 rtl/mp_beat_counter.sv | 26 ++
 rtl/matrix_vector_sequencer.sv | 163 ++++++++++++++++
 tb/tb_matrix_vector_sequencer.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mp_pkg.sv
// Shared types and sizing helpers for the matrix processor control path.
package mp_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_MATRIX,
        LOAD_VECTOR,
        PROCESS,
        NORMALIZE,
        DONE
    } mvs_state_t;

    // Bits needed to index one element of a dim-wide vector.
    function automatic int log2Dim(input int dim);
        return $clog2(dim);
    endfunction

    // Bits needed to index one element of a dim x dim matrix.
    function automatic int idxW(input int dim);
        return $clog2(dim * dim);
    endfunction

endpackage

// File: rtl/mp_beat_counter.sv
// Beat index register: advances on enable, wraps to zero when it reaches the limit.
module mp_beat_counter
    import mp_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] limit,
    output logic [W-1:0] idx,
    output logic         atLimit
);

    assign atLimit = (idx == limit);

    // Index register; clear wins over enable so IDLE always restarts from zero.
    always_ff @(posedge clk) begin
        if (!rst_n || clr)
            idx <= '0;
        else if (en)
            idx <= atLimit ? '0 : idx + 1'b1;
    end

endmodule

// File: rtl/matrix_vector_sequencer.sv
// Control FSM: loads a DIMxDIM matrix, streams vectors through the FMA path,
// optionally normalises each result vector, and pulses done at job end.
module matrix_vector_sequencer
    import mp_pkg::*;
#(
    parameter int DIM     = 4,
    parameter int WI_W    = 16,
    parameter bit NORM_EN = 1'b1,
    localparam int IDX_W  = idxW(DIM)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             keep_matrix,
    input  logic [WI_W-1:0]  wi_count,
    input  logic             in_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] idx,
    output logic             load_matrix,
    output logic             load_vector,
    output logic             read_addr_src,
    output logic             en_fma,
    output logic             write_en,
    output logic             norm_en,
    output logic             busy,
    output logic             done,
    output logic             matrix_valid
);

    localparam int LOG2DIM = log2Dim(DIM);
    localparam logic [IDX_W-1:0] LIM_MAT = IDX_W'(DIM * DIM - 1);
    localparam logic [IDX_W-1:0] LIM_VEC = IDX_W'(DIM - 1);

    mvs_state_t      state, stateNext;
    logic [WI_W-1:0] remaining, remainingNext;
    logic            matrixValid, matrixValidNext;

    logic [IDX_W-1:0] idxCnt;
    logic [IDX_W-1:0] limit;
    logic             atLimit;
    logic             beat;
    logic             rowEnd;

    logic ldMat, ldVec, vecSpace, fma, wr, nrm, dn;

    assign rowEnd = (idxCnt[LOG2DIM-1:0] == {LOG2DIM{1'b1}});

    mp_beat_counter #(.W(IDX_W)) uBeat (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (beat),
        .clr     (state == IDLE),
        .limit   (limit),
        .idx     (idxCnt),
        .atLimit (atLimit)
    );

    // State, job counter and matrix residency flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            remaining   <= '0;
            matrixValid <= 1'b0;
        end else begin
            state       <= stateNext;
            remaining   <= remainingNext;
            matrixValid <= matrixValidNext;
        end
    end

    // Next-state, beat qualification and strobe decode.
    always_comb begin
        stateNext       = state;
        remainingNext   = remaining;
        matrixValidNext = matrixValid;
        beat            = 1'b0;
        limit           = LIM_VEC;
        ldMat           = 1'b0;
        ldVec           = 1'b0;
        vecSpace        = 1'b0;
        fma             = 1'b0;
        wr              = 1'b0;
        nrm             = 1'b0;
        dn              = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    remainingNext = wi_count;
                    if (wi_count == '0) begin
                        stateNext = DONE;
                    end else if (keep_matrix && matrixValid) begin
                        stateNext = LOAD_VECTOR;
                    end else begin
                        // Matrix is about to be overwritten; it is not resident until reloaded.
                        stateNext       = LOAD_MATRIX;
                        matrixValidNext = 1'b0;
                    end
                end
            end
            LOAD_MATRIX: begin
                limit = LIM_MAT;
                ldMat = in_valid;
                beat  = in_valid;
                if (beat && atLimit) begin
                    matrixValidNext = 1'b1;
                    stateNext       = LOAD_VECTOR;
                end
            end
            LOAD_VECTOR: begin
                vecSpace = 1'b1;
                ldVec    = in_valid;
                beat     = in_valid;
                if (beat && atLimit)
                    stateNext = PROCESS;
            end
            PROCESS: begin
                limit = LIM_MAT;
                // Without a normalise pass the row result is written straight out,
                // so the row-end beat must wait for the sink.
                if (rowEnd && !NORM_EN) begin
                    wr   = out_ready;
                    beat = out_ready;
                end else begin
                    beat = 1'b1;
                end
                fma = beat;
                if (beat && atLimit) begin
                    if (remaining != '0)
                        remainingNext = remaining - 1'b1;
                    if (NORM_EN)
                        stateNext = NORMALIZE;
                    else
                        stateNext = (remaining <= 1) ? DONE : LOAD_VECTOR;
                end
            end
            NORMALIZE: begin
                nrm  = 1'b1;
                wr   = out_ready;
                beat = out_ready;
                if (beat && atLimit)
                    stateNext = (remaining == '0) ? DONE : LOAD_VECTOR;
            end
            DONE: begin
                dn        = 1'b1;
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // Reset is synchronous, so outputs are forced low combinationally while it is held.
    assign idx           = rst_n ? idxCnt : '0;
    assign load_matrix   = rst_n & ldMat;
    assign load_vector   = rst_n & ldVec;
    assign read_addr_src = rst_n & vecSpace;
    assign en_fma        = rst_n & fma;
    assign write_en      = rst_n & wr;
    assign norm_en       = rst_n & nrm;
    assign busy          = rst_n & (state != IDLE);
    assign done          = rst_n & dn;
    assign matrix_valid  = rst_n & matrixValid;

endmodule

// File: tb/tb_matrix_vector_sequencer.sv
// Bench for matrix_vector_sequencer: two instances (no normalise / normalise)
// share stimulus; a step-list model predicts every output on every cycle.
module tb_matrix_vector_sequencer;
    import mp_pkg::*;

    localparam int DIM   = 4;
    localparam int WI_W  = 16;
    localparam int IDX_W = idxW(DIM);

    localparam logic [2:0] SK_LM = 3'd0, SK_LV = 3'd1, SK_PR = 3'd2, SK_NM = 3'd3, SK_DN = 3'd4;
    // gate: 0 always advances, 1 advances on in_valid, 2 advances on out_ready
    typedef struct packed {
        logic [2:0] kind;
        logic [7:0] idx;
        logic [1:0] gate;
        logic       setMv;
    } step_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic            keepMatrix = 1'b0;
    logic [WI_W-1:0] wiCount = '0;
    logic            inValid = 1'b0;
    logic            outReady = 1'b0;

    logic [IDX_W-1:0] idxO [2];
    logic [1:0] lmO, lvO, rasO, fmaO, weO, nmO, busyO, doneO, mvO;

    int tests = 0;
    int fails = 0;

    step_t steps [2][0:511];
    int    head [2];
    int    tail [2];
    bit    mvM [2];

    int cntLm [2], cntLv [2], cntFma [2], cntWe [2], cntNm [2], cntBusy [2], cntDone [2];
    int wrIdx [$];

    always #5 clk = ~clk;

    matrix_vector_sequencer #(.DIM(DIM), .WI_W(WI_W), .NORM_EN(1'b0)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start), .keep_matrix(keepMatrix), .wi_count(wiCount),
        .in_valid(inValid), .out_ready(outReady), .idx(idxO[0]), .load_matrix(lmO[0]),
        .load_vector(lvO[0]), .read_addr_src(rasO[0]), .en_fma(fmaO[0]), .write_en(weO[0]),
        .norm_en(nmO[0]), .busy(busyO[0]), .done(doneO[0]), .matrix_valid(mvO[0])
    );

    matrix_vector_sequencer #(.DIM(DIM), .WI_W(WI_W), .NORM_EN(1'b1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start), .keep_matrix(keepMatrix), .wi_count(wiCount),
        .in_valid(inValid), .out_ready(outReady), .idx(idxO[1]), .load_matrix(lmO[1]),
        .load_vector(lvO[1]), .read_addr_src(rasO[1]), .en_fma(fmaO[1]), .write_en(weO[1]),
        .norm_en(nmO[1]), .busy(busyO[1]), .done(doneO[1]), .matrix_valid(mvO[1])
    );

    task automatic pushStep(input int m, input logic [2:0] k, input int i, input int g, input bit smv);
        steps[m][tail[m]] = '{kind: k, idx: 8'(i), gate: 2'(g), setMv: smv};
        tail[m]++;
    endtask

    // Expand a job into the exact list of cycles it must take.
    task automatic buildJob(input int m, input int wi, input bit keep);
        bit normOn;
        normOn  = (m == 1);
        head[m] = 0;
        tail[m] = 0;
        if (wi != 0) begin
            if (!(keep && mvM[m])) begin
                mvM[m] = 1'b0;
                for (int i = 0; i < DIM * DIM; i++) pushStep(m, SK_LM, i, 1, i == DIM * DIM - 1);
            end
            for (int v = 0; v < wi; v++) begin
                for (int i = 0; i < DIM; i++) pushStep(m, SK_LV, i, 1, 1'b0);
                for (int i = 0; i < DIM * DIM; i++)
                    pushStep(m, SK_PR, i, ((i % DIM == DIM - 1) && !normOn) ? 2 : 0, 1'b0);
                if (normOn)
                    for (int i = 0; i < DIM; i++) pushStep(m, SK_NM, i, 2, 1'b0);
            end
        end
        pushStep(m, SK_DN, 0, 0, 1'b0);
    endtask

    task automatic checkEq(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Per-cycle model compare and activity counters.
    step_t      s;
    logic       gateOk;
    logic [12:0] expV, actV;
    always @(negedge clk) begin
        for (int m = 0; m < 2; m++) begin
            cntLm[m]   += int'(lmO[m]);
            cntLv[m]   += int'(lvO[m]);
            cntFma[m]  += int'(fmaO[m]);
            cntWe[m]   += int'(weO[m]);
            cntNm[m]   += int'(nmO[m]);
            cntBusy[m] += int'(busyO[m]);
            cntDone[m] += int'(doneO[m]);
            if (m == 0 && weO[0]) wrIdx.push_back(int'(idxO[0]));

            actV = {idxO[m], lmO[m], lvO[m], rasO[m], fmaO[m], weO[m], nmO[m], busyO[m], doneO[m], mvO[m]};
            expV = '0;
            if (!rst_n) begin
                head[m] = 0;
                tail[m] = 0;
                mvM[m]  = 1'b0;
            end else if (head[m] == tail[m]) begin
                expV[0] = mvM[m];
                if (start) buildJob(m, int'(wiCount), keepMatrix);
            end else begin
                s = steps[m][head[m]];
                gateOk = (s.gate == 0) ? 1'b1 : (s.gate == 1) ? inValid : outReady;
                expV[12:9] = s.idx[3:0];
                expV[2] = 1'b1;
                expV[0] = mvM[m];
                case (s.kind)
                    SK_LM: expV[8] = inValid;
                    SK_LV: begin expV[7] = inValid; expV[6] = 1'b1; end
                    SK_PR: begin expV[5] = gateOk; expV[4] = (s.gate == 2) && outReady; end
                    SK_NM: begin expV[3] = 1'b1; expV[4] = outReady; end
                    default: expV[1] = 1'b1;
                endcase
                if (gateOk) begin
                    if (s.setMv) mvM[m] = 1'b1;
                    head[m]++;
                end
            end
            tests++;
            if (actV !== expV) begin
                fails++;
                $display("FAIL outputs inst%0d t=%0t {idx,lm,lv,ras,fma,we,nm,busy,done,mv}: got %h, want %h",
                         m, $time, actV, expV);
            end
        end
    end

    task automatic clearCounts();
        for (int m = 0; m < 2; m++) begin
            cntLm[m] = 0; cntLv[m] = 0; cntFma[m] = 0; cntWe[m] = 0;
            cntNm[m] = 0; cntBusy[m] = 0; cntDone[m] = 0;
        end
        wrIdx.delete();
    endtask

    // mode 0: everything ready; mode 1: in_valid toggles, out_ready drops 3 of every 7 cycles,
    // plus a stray start that the busy sequencer must ignore.
    task automatic drive(input int mode, input int n);
        if (mode == 0) begin
            inValid  = 1'b1;
            outReady = 1'b1;
            start    = 1'b0;
        end else begin
            inValid  = (n % 2 == 0);
            outReady = !((n % 7) < 3);
            start    = (n == 5);
        end
    endtask

    task automatic runJob(input int wi, input bit keep, input int mode, input int maxCyc);
        int n;
        @(posedge clk); #1;
        clearCounts();
        start = 1'b1; wiCount = WI_W'(wi); keepMatrix = keep; inValid = 1'b1; outReady = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; keepMatrix = 1'b0; wiCount = '1;
        n = 0;
        drive(mode, n);
        @(negedge clk);
        while (busyO != 2'b00 && n < maxCyc) begin
            @(posedge clk); #1;
            n++;
            drive(mode, n);
            @(negedge clk);
        end
        if (n >= maxCyc) begin
            tests++;
            fails++;
            $display("FAIL job timeout: still busy after %0d cycles, want idle", n);
        end
        @(posedge clk); #1;
        drive(0, 0);
    endtask

    task automatic doReset(input int cycles);
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        for (int m = 0; m < 2; m++) begin head[m] = 0; tail[m] = 0; mvM[m] = 1'b0; end
        clearCounts();
        @(negedge clk);
        checkEq("reset busy", int'(busyO), 0);
        checkEq("reset idx", int'(idxO[0]), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Two vectors, no stalls.
        runJob(2, 1'b0, 0, 200);
        checkEq("t1 load_matrix", cntLm[0], 16);
        checkEq("t1 load_vector", cntLv[0], 8);
        checkEq("t1 en_fma", cntFma[0], 32);
        checkEq("t1 writes", cntWe[0], 8);
        checkEq("t1 busy cycles", cntBusy[0], 57);
        checkEq("t1 done pulses", cntDone[0], 1);
        for (int i = 0; i < 8; i++)
            checkEq("t1 write idx", (i < wrIdx.size()) ? wrIdx[i] : -1, (i % 4) * 4 + 3);
        checkEq("t1n writes", cntWe[1], 8);
        checkEq("t1n norm beats", cntNm[1], 8);
        checkEq("t1n busy cycles", cntBusy[1], 65);

        // Empty job.
        runJob(0, 1'b0, 0, 20);
        checkEq("t2 busy cycles", cntBusy[0], 1);
        checkEq("t2 done pulses", cntDone[0], 1);
        checkEq("t2 strobes", cntLm[0] + cntLv[0] + cntFma[0] + cntWe[0], 0);

        // Matrix reuse.
        runJob(1, 1'b1, 0, 100);
        checkEq("t3 load_matrix", cntLm[0] + cntLm[1], 0);
        checkEq("t3 writes", cntWe[0], 4);
        checkEq("t3 busy cycles", cntBusy[0], 21);

        // Reuse requested after reset forces a reload.
        doReset(2);
        runJob(1, 1'b1, 0, 100);
        checkEq("t4 load_matrix", cntLm[0], 16);
        checkEq("t4 busy cycles", cntBusy[0], 37);

        // Input and output stalls.
        runJob(2, 1'b0, 1, 1000);
        checkEq("t5 load_matrix", cntLm[0], 16);
        checkEq("t5 load_vector", cntLv[0], 8);
        checkEq("t5 en_fma", cntFma[0], 32);
        checkEq("t5 writes", cntWe[0], 8);
        checkEq("t5n writes", cntWe[1], 8);
        checkEq("t5 done pulses", cntDone[0], 1);

        // Reset in the middle of PROCESS.
        @(posedge clk); #1;
        start = 1'b1; wiCount = 16'd1; keepMatrix = 1'b0; inValid = 1'b1; outReady = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (22) @(posedge clk);
        @(negedge clk);
        checkEq("t6 in process", int'(fmaO[0]), 1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        checkEq("t6 busy in reset", int'(busyO), 0);
        checkEq("t6 fma in reset", int'(fmaO), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkEq("t6 matrix_valid", int'(mvO), 0);
        runJob(1, 1'b1, 0, 100);
        checkEq("t6 reload", cntLm[0], 16);
        checkEq("t6 writes", cntWe[0], 4);

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
